// File: rtl/conv_encoder_k3_if.sv
// Byte-in / coded-symbol-out handshake bundle for the K=3 convolutional encoder.
// slave = encoder side, master = producer/consumer side.
interface conv_encoder_k3_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       sym_valid;
  logic       sym_ready;
  logic [1:0] sym;
  logic       sym_last;

  modport slave (
    input  in_valid, in_data, in_last, sym_ready,
    output in_ready, sym_valid, sym, sym_last
  );

  modport master (
    output in_valid, in_data, in_last, sym_ready,
    input  in_ready, sym_valid, sym, sym_last
  );
endinterface

// File: rtl/conv_encoder_k3.sv
// Rate-1/2, constraint-length-3 convolutional encoder: one byte in, eight coded
// symbol pairs out MSB first, plus optional two zero-input tail symbols per frame.
module conv_encoder_k3 #(
  parameter logic [2:0] G0      = 3'b111,
  parameter logic [2:0] G1      = 3'b101,
  parameter bit         TAIL_EN = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  conv_encoder_k3_if.slave    bus,
  output logic                o_busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] TAIL  = 2'd2;

  logic [1:0] r_fsm;
  logic [1:0] r_enc;
  logic [2:0] r_cnt;
  logic [7:0] r_byte;
  logic       r_last;

  logic       w_active;
  logic       w_b;
  logic [2:0] w_win;

  assign w_active = (r_fsm == SHIFT) || (r_fsm == TAIL);
  assign w_b      = (r_fsm == SHIFT) ? r_byte[3'd7 - r_cnt] : 1'b0;
  assign w_win    = {w_b, r_enc};

  assign bus.in_ready  = (r_fsm == IDLE) && !i_rst;
  assign bus.sym_valid = w_active;
  assign bus.sym       = w_active ? {^(G0 & w_win), ^(G1 & w_win)} : 2'b00;
  assign bus.sym_last  = ((r_fsm == TAIL) && (r_cnt == 3'd1)) ||
                         ((r_fsm == SHIFT) && (r_cnt == 3'd7) && r_last && !TAIL_EN);
  assign o_busy        = (r_fsm != IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fsm  <= IDLE;
      r_enc  <= '0;
      r_cnt  <= '0;
      r_byte <= '0;
      r_last <= 1'b0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (bus.in_valid) begin
            r_byte <= bus.in_data;
            r_last <= bus.in_last;
            r_cnt  <= '0;
            r_fsm  <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.sym_ready) begin
            r_enc <= {w_b, r_enc[1]};
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              r_cnt <= '0;
              if (r_last && TAIL_EN) begin
                r_fsm <= TAIL;
              end else begin
                r_fsm <= IDLE;
                // end of frame without tail still starts the next frame from 00
                if (r_last) r_enc <= '0;
              end
            end
          end
        end
        TAIL: begin
          if (bus.sym_ready) begin
            r_enc <= {1'b0, r_enc[1]};
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == 3'd1) begin
              r_fsm <= IDLE;
              r_enc <= '0;
              r_cnt <= '0;
            end
          end
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/conv_encoder_k3.md
CONV_ENCODER_K3 -- requirements
Module: conv_encoder_k3

Interface
REQ-001 SHALL have parameter G0, default 3'b111, generator for sym[1] (octal 7; bit2 taps input, bit1 taps s1, bit0 taps s0).
REQ-002 SHALL have parameter G1, default 3'b101, generator for sym[0] (octal 5; same tap ordering).
REQ-003 SHALL have parameter TAIL_EN, default 1: when 1, a frame ending with in_last is followed by 2 zero-input tail symbols.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  in_data/in_last offered.
REQ-007 in_ready  output  1  encoder can accept a byte.
REQ-008 in_data  input  8  payload byte, encoded MSB first.
REQ-009 in_last  input  1  byte is final in frame.
REQ-010 sym_valid  output  1  sym/sym_last valid.
REQ-011 sym_ready  input  1  downstream accepts symbol.
REQ-012 sym  output  2  coded pair {G0 out, G1 out}.
REQ-013 sym_last  output  1  final symbol of frame.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL hold a 2-bit encoder state {s1,s0}, s1 = most recent input bit; sym[1] = XOR of (G0 & {b,s1,s0}), sym[0] = XOR of (G1 & {b,s1,s0}), b = current input bit.
REQ-016 SHALL implement FSM IDLE, SHIFT, TAIL.
REQ-017 IDLE: in_ready=1, sym_valid=0; on in_valid & in_ready, latch in_data and in_last, clear bit counter, go SHIFT.
REQ-018 in_ready SHALL be 0 in SHIFT and TAIL; in_valid there is ignored and no data latched.
REQ-019 SHIFT: sym_valid=1, b = latched byte bit (7 - counter); on sym_valid & sym_ready, update state to {b,s1}, increment counter.
REQ-020 After handshake of 8th SHIFT symbol: if latched last and TAIL_EN=1, go TAIL; else go IDLE.
REQ-021 TAIL: sym_valid=1, b=0; two handshaked symbols, then IDLE with state 00.
REQ-022 sym_last SHALL be 1 only on 2nd TAIL symbol (TAIL_EN=1), or on 8th SHIFT symbol when latched last and TAIL_EN=0; otherwise 0.
REQ-023 With sym_ready=0, sym, sym_last, sym_valid and all state SHALL hold unchanged.
REQ-024 Encoder state SHALL persist across bytes of the same frame (not cleared on IDLE when last=0).
REQ-025 Latency: first symbol of a byte valid in the cycle after the input handshake; one symbol per cycle when sym_ready=1; one IDLE cycle between bytes.
REQ-026 With TAIL_EN=0 and last=1, encoder state SHALL still clear to 00 on return to IDLE.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, state 00, counter 0, latched byte/last 0; outputs in_ready=1 (once rst low; 0 during rst), sym_valid=0, sym=00, sym_last=0, busy=0.
REQ-028 Reset mid-frame SHALL discard the pending byte and remaining symbols; no sym_valid after reset until new byte handshake.

Verification
REQ-029 Defaults, 0x80 in_last=1, sym_ready=1 -> syms 11,10,11,00,00,00,00,00,00,00; sym_last on 10th only.
REQ-030 0xA0 in_last=1 -> 11,10,00,10,11,00,00,00,00,00; sym_last on 10th.
REQ-031 0xFF in_last=0 then 0x00 in_last=1 -> 11,01,10,10,10,10,10,10, then 01,11,00,00,00,00,00,00,00,00; sym_last only on 18th symbol overall.
REQ-032 0x80 in_last=1 with sym_ready toggling 1,0 each cycle -> same 10-symbol sequence as REQ-029, outputs stable while sym_ready=0; in_valid pulsed mid-frame leaves in_ready=0 and is ignored.
REQ-033 Assert rst after 3rd symbol of 0x80 frame -> sym_valid=0 and busy=0 immediately; next byte 0x80 in_last=1 reproduces REQ-029 from state 00.
REQ-034 TAIL_EN=0, 0x80 in_last=1 -> 11,10,11,00,00,00,00,00 with sym_last on 8th; following 0x80 again begins 11.
